// File: rtl/fadd_align_cal_buf_pkg.sv
// Shared floating-point adder types: precision presets, the aligned-operand
// bundle layout and the skid-buffer state encoding.
package fp_pkg;

    localparam int SP_EXP_W  = 8;
    localparam int SP_FRAC_W = 23;
    localparam int DP_EXP_W  = 11;
    localparam int DP_FRAC_W = 52;

    // Single-precision form; width-generic modules declare the same layout locally.
    typedef struct packed {
        logic [1:0]             rm;
        logic                   is_nan;
        logic                   is_inf;
        logic                   sign;
        logic                   op_sub;
        logic [SP_FRAC_W-1:0]   inf_nan_frac;
        logic [SP_EXP_W-1:0]    exp;
        logic [SP_FRAC_W:0]     large_frac;
        logic [SP_FRAC_W+3:0]   small_frac;
    } align_cal_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    function automatic int payload_w(input int exp_w, input int frac_w);
        return 3 * frac_w + exp_w + 11;
    endfunction

endpackage

// File: rtl/fadd_align_cal_buf_skid.sv
// Generic two-entry valid/ready skid buffer with synchronous flush and occupancy.
// state | meaning
// EMPTY | nothing held, c_valid=0
// BUSY  | main holds the head bundle
// FULL  | main holds the head, skid holds the next bundle; upstream stalled
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         flush,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] a_data,
    output logic         c_valid,
    input  logic         c_ready,
    output logic [W-1:0] c_data,
    output logic [1:0]   c_count
);
    import fp_pkg::*;

    buf_state_t     r_state;
    buf_state_t     w_next;
    logic [W-1:0]   r_main;
    logic [W-1:0]   r_skid;
    logic           w_load_main;
    logic           w_load_skid;
    logic           w_skid_to_main;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_main)
                r_main <= a_data;
            else if (w_skid_to_main)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= a_data;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        c_valid        = 1'b0;
        a_ready        = 1'b1;
        c_count        = 2'd0;
        case (r_state)
            EMPTY: begin
                if (a_valid) begin
                    w_load_main = 1'b1;
                    w_next      = BUSY;
                end
            end
            BUSY: begin
                c_valid = 1'b1;
                c_count = 2'd1;
                if (a_valid && c_ready) begin
                    w_load_main = 1'b1;
                end else if (a_valid) begin
                    w_load_skid = 1'b1;
                    w_next      = FULL;
                end else if (c_ready) begin
                    w_next = EMPTY;
                end
            end
            FULL: begin
                c_valid = 1'b1;
                a_ready = 1'b0;
                c_count = 2'd2;
                if (c_ready) begin
                    w_skid_to_main = 1'b1;
                    w_next         = BUSY;
                end
            end
            default: w_next = EMPTY;
        endcase
        // Flush only drops the valid state; suppressing the loads keeps a dropped bundle out of main.
        if (flush) begin
            w_next         = EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    assign c_data = r_main;

endmodule

// File: rtl/fadd_align_cal_buf.sv
// Flow-controlled register stage carrying the aligned-operand bundle from the
// alignment stage to the calculation stage of the FP adder.
module fadd_align_cal_buf
    import fp_pkg::*;
#(
    parameter int EXP_W  = SP_EXP_W,
    parameter int FRAC_W = SP_FRAC_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [1:0]        a_rm,
    input  logic              a_is_nan,
    input  logic              a_is_inf,
    input  logic              a_sign,
    input  logic              a_op_sub,
    input  logic [FRAC_W-1:0] a_inf_nan_frac,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [FRAC_W:0]   a_large_frac,
    input  logic [FRAC_W+3:0] a_small_frac,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [1:0]        c_rm,
    output logic              c_is_nan,
    output logic              c_is_inf,
    output logic              c_sign,
    output logic              c_op_sub,
    output logic [FRAC_W-1:0] c_inf_nan_frac,
    output logic [EXP_W-1:0]  c_exp,
    output logic [FRAC_W:0]   c_large_frac,
    output logic [FRAC_W+3:0] c_small_frac,
    output logic [1:0]        c_count
);

    localparam int W = payload_w(EXP_W, FRAC_W);

    // Same field order as align_cal_t, sized by this instance's parameters.
    typedef struct packed {
        logic [1:0]          rm;
        logic                is_nan;
        logic                is_inf;
        logic                sign;
        logic                op_sub;
        logic [FRAC_W-1:0]   inf_nan_frac;
        logic [EXP_W-1:0]    exp;
        logic [FRAC_W:0]     large_frac;
        logic [FRAC_W+3:0]   small_frac;
    } bundle_t;

    bundle_t w_a_bundle;
    bundle_t w_c_bundle;

    assign w_a_bundle = '{
        rm:           a_rm,
        is_nan:       a_is_nan,
        is_inf:       a_is_inf,
        sign:         a_sign,
        op_sub:       a_op_sub,
        inf_nan_frac: a_inf_nan_frac,
        exp:          a_exp,
        large_frac:   a_large_frac,
        small_frac:   a_small_frac
    };

    skid_buf #(
        .W(W)
    ) u_skid (
        .clk     (clk),
        .clr     (clr),
        .flush   (flush),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (w_a_bundle),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .c_data  (w_c_bundle),
        .c_count (c_count)
    );

    assign c_rm           = w_c_bundle.rm;
    assign c_is_nan       = w_c_bundle.is_nan;
    assign c_is_inf       = w_c_bundle.is_inf;
    assign c_sign         = w_c_bundle.sign;
    assign c_op_sub       = w_c_bundle.op_sub;
    assign c_inf_nan_frac = w_c_bundle.inf_nan_frac;
    assign c_exp          = w_c_bundle.exp;
    assign c_large_frac   = w_c_bundle.large_frac;
    assign c_small_frac   = w_c_bundle.small_frac;

endmodule

// File: tb/tb_fadd_align_cal_buf.sv
// Bench for fadd_align_cal_buf: directed and random traffic checked against a
// two-deep FIFO reference model, plus a double-precision instance.
module tb_fadd_align_cal_buf;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    string ph = "reset";

    // Single-precision instance: whole bundle as one 88-bit vector, rm at the top.
    logic        sp_flush = 1'b0, sp_a_valid = 1'b0, sp_c_ready = 1'b0;
    logic [87:0] sp_in = '0;
    logic        sp_a_ready, sp_c_valid;
    logic [1:0]  sp_c_count;
    logic [1:0]  sp_rm;
    logic        sp_nan, sp_inf, sp_sign, sp_sub;
    logic [22:0] sp_infnan;
    logic [7:0]  sp_exp;
    logic [23:0] sp_large;
    logic [26:0] sp_small;
    logic [87:0] sp_out;
    assign sp_out = {sp_rm, sp_nan, sp_inf, sp_sign, sp_sub, sp_infnan, sp_exp, sp_large, sp_small};

    fadd_align_cal_buf u_sp (
        .clk(clk), .clr(clr), .flush(sp_flush), .a_valid(sp_a_valid), .a_ready(sp_a_ready),
        .a_rm(sp_in[87:86]), .a_is_nan(sp_in[85]), .a_is_inf(sp_in[84]), .a_sign(sp_in[83]),
        .a_op_sub(sp_in[82]), .a_inf_nan_frac(sp_in[81:59]), .a_exp(sp_in[58:51]),
        .a_large_frac(sp_in[50:27]), .a_small_frac(sp_in[26:0]),
        .c_valid(sp_c_valid), .c_ready(sp_c_ready), .c_rm(sp_rm), .c_is_nan(sp_nan),
        .c_is_inf(sp_inf), .c_sign(sp_sign), .c_op_sub(sp_sub), .c_inf_nan_frac(sp_infnan),
        .c_exp(sp_exp), .c_large_frac(sp_large), .c_small_frac(sp_small), .c_count(sp_c_count)
    );

    // Double-precision instance: 178-bit bundle.
    logic         dp_flush = 1'b0, dp_a_valid = 1'b0, dp_c_ready = 1'b0;
    logic [177:0] dp_in = '0;
    logic         dp_a_ready, dp_c_valid;
    logic [1:0]   dp_c_count;
    logic [1:0]   dp_rm;
    logic         dp_nan, dp_inf, dp_sign, dp_sub;
    logic [51:0]  dp_infnan;
    logic [10:0]  dp_exp;
    logic [52:0]  dp_large;
    logic [55:0]  dp_small;
    logic [177:0] dp_out;
    logic [177:0] dp_exp_bundle;
    assign dp_out = {dp_rm, dp_nan, dp_inf, dp_sign, dp_sub, dp_infnan, dp_exp, dp_large, dp_small};

    fadd_align_cal_buf #(.EXP_W(11), .FRAC_W(52)) u_dp (
        .clk(clk), .clr(clr), .flush(dp_flush), .a_valid(dp_a_valid), .a_ready(dp_a_ready),
        .a_rm(dp_in[177:176]), .a_is_nan(dp_in[175]), .a_is_inf(dp_in[174]), .a_sign(dp_in[173]),
        .a_op_sub(dp_in[172]), .a_inf_nan_frac(dp_in[171:120]), .a_exp(dp_in[119:109]),
        .a_large_frac(dp_in[108:56]), .a_small_frac(dp_in[55:0]),
        .c_valid(dp_c_valid), .c_ready(dp_c_ready), .c_rm(dp_rm), .c_is_nan(dp_nan),
        .c_is_inf(dp_inf), .c_sign(dp_sign), .c_op_sub(dp_sub), .c_inf_nan_frac(dp_infnan),
        .c_exp(dp_exp), .c_large_frac(dp_large), .c_small_frac(dp_small), .c_count(dp_c_count)
    );

    // Reference model: the stage behaves as an in-order FIFO of depth two.
    logic [87:0] q[$];

    function automatic logic [87:0] rand88();
        logic [87:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[87:64] = 24'($urandom());
        return r;
    endfunction

    function automatic logic [87:0] mk(input logic [7:0] e);
        logic [87:0] r;
        r = rand88();
        r[58:51] = e;
        return r;
    endfunction

    task automatic check_outputs();
        total++;
        assert (sp_c_valid === (q.size() != 0))
            else begin bad++; $error("FAIL %s c_valid observed=%b expected=%b", ph, sp_c_valid, q.size() != 0); end
        total++;
        assert (sp_c_count === 2'(q.size()))
            else begin bad++; $error("FAIL %s c_count observed=%0d expected=%0d", ph, sp_c_count, q.size()); end
        total++;
        assert (sp_a_ready === (q.size() < 2))
            else begin bad++; $error("FAIL %s a_ready observed=%b expected=%b", ph, sp_a_ready, q.size() < 2); end
        if (q.size() != 0) begin
            total++;
            assert (sp_out === q[0])
                else begin bad++; $error("FAIL %s payload observed=%h expected=%h", ph, sp_out, q[0]); end
        end
    endtask

    // Called at a falling edge: check what is showing, drive the next edge's inputs, advance one cycle.
    task automatic cycle(input logic av, input logic [87:0] d, input logic cr, input logic fl,
                         output logic acc);
        check_outputs();
        sp_a_valid = av;
        sp_in      = d;
        sp_c_ready = cr;
        sp_flush   = fl;
        acc = av && (q.size() < 2) && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && cr) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        total++;
        assert (sp_c_valid === 1'b0 && sp_c_count === 2'd0 && sp_a_ready === 1'b1)
            else begin bad++; $error("FAIL %s sp_ctrl observed=%b%0d%b expected=001", ph, sp_c_valid, sp_c_count, sp_a_ready); end
        total++;
        assert (sp_out === 88'h0)
            else begin bad++; $error("FAIL %s sp_payload observed=%h expected=0", ph, sp_out); end
        total++;
        assert (dp_c_valid === 1'b0 && dp_c_count === 2'd0 && dp_a_ready === 1'b1 && dp_out === 178'h0)
            else begin bad++; $error("FAIL %s dp_state observed=%b%0d%b %h expected=001 0", ph, dp_c_valid, dp_c_count, dp_a_ready, dp_out); end
    endtask

    logic        acc;
    logic        pend_v;
    logic [87:0] pend_d;
    logic        rcr, rfl;

    initial begin
        #1;
        check_reset_state();
        @(negedge clk);
        clr = 1'b0;

        ph = "dp";
        dp_exp_bundle = '0;
        dp_exp_bundle[177:176] = 2'b10;
        dp_exp_bundle[174]     = 1'b1;
        dp_exp_bundle[173]     = 1'b1;
        dp_exp_bundle[119:109] = 11'h7FF;
        dp_exp_bundle[108:56]  = 53'h1F_FFFF_FFFF_FFFF;
        dp_exp_bundle[55]      = 1'b1;
        dp_exp_bundle[0]       = 1'b1;
        dp_in      = dp_exp_bundle;
        dp_a_valid = 1'b1;
        dp_c_ready = 1'b1;
        @(negedge clk);
        dp_a_valid = 1'b0;
        dp_in      = '0;
        total++;
        assert (dp_c_valid === 1'b1 && dp_c_count === 2'd1)
            else begin bad++; $error("FAIL dp_valid observed=%b/%0d expected=1/1", dp_c_valid, dp_c_count); end
        total++;
        assert (dp_out === dp_exp_bundle)
            else begin bad++; $error("FAIL dp_payload observed=%h expected=%h", dp_out, dp_exp_bundle); end
        @(negedge clk);
        total++;
        assert (dp_c_valid === 1'b0)
            else begin bad++; $error("FAIL dp_drain observed=%b expected=0", dp_c_valid); end

        ph = "stream";
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(8'(8'h80 + i)), 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        ph = "backpressure";
        cycle(1'b1, mk(8'h10), 1'b0, 1'b0, acc);
        cycle(1'b1, mk(8'h11), 1'b0, 1'b0, acc);
        pend_d = mk(8'h12);
        for (int i = 0; i < 3; i++) cycle(1'b1, pend_d, 1'b0, 1'b0, acc);
        for (int i = 0; i < 2; i++) cycle(1'b1, pend_d, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);

        ph = "flush_full";
        cycle(1'b1, mk(8'h20), 1'b0, 1'b0, acc);
        cycle(1'b1, mk(8'h21), 1'b0, 1'b0, acc);
        cycle(1'b1, mk(8'hDD), 1'b0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        ph = "flush_stall";
        cycle(1'b1, mk(8'h30), 1'b0, 1'b0, acc);
        cycle(1'b1, mk(8'h31), 1'b0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        ph = "async_clr";
        cycle(1'b1, mk(8'h40), 1'b0, 1'b0, acc);
        cycle(1'b1, mk(8'h41), 1'b0, 1'b0, acc);
        check_outputs();
        sp_a_valid = 1'b0;
        #2 clr = 1'b1;
        #1 check_reset_state();
        @(negedge clk);
        clr = 1'b0;
        q.delete();
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        ph = "random";
        pend_v = 1'b0;
        pend_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend_d = rand88();
            end
            rcr = ($urandom_range(0, 3) != 0);
            rfl = ($urandom_range(0, 15) == 0);
            cycle(pend_v, pend_d, rcr, rfl, acc);
            if (acc || rfl) pend_v = 1'b0;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
